// File: rtl/tdc_ms1004_seq_pkg.sv
// Shared opcodes, state/step encodings and command payload for the MS1004 command sequencer.
package tdc_ms1004_seq_pkg;

  localparam int unsigned CMD_W      = 8;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned RES_W      = 24;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned STEP_W     = 4;
  localparam int unsigned GAP_CYCLES = 8;

  localparam logic [CMD_W-1:0] OP_PORST = 8'h50;
  localparam logic [CMD_W-1:0] OP_INIT  = 8'h70;
  localparam logic [CMD_W-1:0] OP_WRREG = 8'h80;
  localparam logic [CMD_W-1:0] OP_RDRES = 8'hB0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_DONE,
    S_GAP,
    S_ARMED,
    S_ERR
  } state_e;

  typedef enum logic [STEP_W-1:0] {
    STEP_RST,
    STEP_CFG0,
    STEP_CFG1,
    STEP_CFG2,
    STEP_CFG3,
    STEP_CFG4,
    STEP_INIT,
    STEP_RD0,
    STEP_RD1
  } step_e;

  typedef enum logic [1:0] {
    KIND_NONE,
    KIND_WR,
    KIND_RD,
    KIND_1B
  } cmd_kind_e;

  typedef struct packed {
    cmd_kind_e         kind;
    logic [CMD_W-1:0]  op;
    logic [DATA_W-1:0] wrdata;
  } cmd_t;

endpackage

// File: rtl/tdc_ms1004_seq.sv
// MS1004 TDC command sequencer: reset/config/init bring-up, arming, interrupt wait and result readout.
module tdc_ms1004_seq
  import tdc_ms1004_seq_pkg::*;
#(
  parameter int unsigned NUM_CFG     = 3,
  parameter logic [31:0] CFG0        = 32'h0042_0000,
  parameter logic [31:0] CFG1        = 32'h2144_0000,
  parameter logic [31:0] CFG2        = 32'h0000_0000,
  parameter logic [31:0] CFG3        = 32'h0000_0000,
  parameter logic [31:0] CFG4        = 32'h0000_0000,
  parameter logic [15:0] INT_TIMEOUT = 16'd50000,
  parameter logic [15:0] CMD_TIMEOUT = 16'd1000
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_cfg_req,
  input  logic              i_meas_req,
  input  logic              i_tdc_intn,
  output logic              o_cmd_wr,
  output logic              o_cmd_rd,
  output logic              o_cmd_1byte,
  output logic [7:0]        o_tdc_cmd,
  output logic [31:0]       o_tdc_wrdata,
  input  logic              i_cmd_ack,
  input  logic              i_cmd_done,
  input  logic [31:0]       i_rd_data,
  output logic              o_configured,
  output logic              o_busy,
  output logic [23:0]       o_res0,
  output logic [23:0]       o_res1,
  output logic              o_res_valid,
  output logic              o_err
);

  localparam logic [STEP_W-1:0] LAST_CFG = STEP_W'(int'(STEP_CFG0) + NUM_CFG - 1);

  state_e             state_q, state_d;
  step_e              step_q, step_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               meas_q, meas_d;
  logic               configured_d, err_d, res_valid_d, busy_d;
  logic [RES_W-1:0]   res0_d, res1_d;
  cmd_t               cmd_d;

  // Only the upper 24 bits of a read carry result data.
  logic unused_rd_lsb;
  assign unused_rd_lsb = ^i_rd_data[7:0];

  function automatic step_e step_after(input step_e s);
    step_e r;
    r = STEP_INIT;
    case (s)
      STEP_RST:  r = STEP_CFG0;
      STEP_CFG0, STEP_CFG1, STEP_CFG2, STEP_CFG3, STEP_CFG4:
        r = (STEP_W'(s) == LAST_CFG) ? STEP_INIT : step_e'(STEP_W'(s) + STEP_W'(1));
      STEP_RD0:  r = STEP_RD1;
      default:   r = STEP_INIT;
    endcase
    return r;
  endfunction

  function automatic cmd_t step_cmd(input step_e s);
    cmd_t c;
    c = '0;
    case (s)
      STEP_RST:  begin c.kind = KIND_1B; c.op = OP_PORST; end
      STEP_CFG0: begin c.kind = KIND_WR; c.op = OP_WRREG | 8'h00; c.wrdata = CFG0; end
      STEP_CFG1: begin c.kind = KIND_WR; c.op = OP_WRREG | 8'h01; c.wrdata = CFG1; end
      STEP_CFG2: begin c.kind = KIND_WR; c.op = OP_WRREG | 8'h02; c.wrdata = CFG2; end
      STEP_CFG3: begin c.kind = KIND_WR; c.op = OP_WRREG | 8'h03; c.wrdata = CFG3; end
      STEP_CFG4: begin c.kind = KIND_WR; c.op = OP_WRREG | 8'h04; c.wrdata = CFG4; end
      STEP_INIT: begin c.kind = KIND_1B; c.op = OP_INIT; end
      STEP_RD0:  begin c.kind = KIND_RD; c.op = OP_RDRES | 8'h00; end
      STEP_RD1:  begin c.kind = KIND_RD; c.op = OP_RDRES | 8'h01; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  // State, step, counter and every output are registered here.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      step_q       <= STEP_RST;
      cnt_q        <= '0;
      meas_q       <= 1'b0;
      o_cmd_wr     <= 1'b0;
      o_cmd_rd     <= 1'b0;
      o_cmd_1byte  <= 1'b0;
      o_tdc_cmd    <= '0;
      o_tdc_wrdata <= '0;
      o_configured <= 1'b0;
      o_busy       <= 1'b0;
      o_res0       <= '0;
      o_res1       <= '0;
      o_res_valid  <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      meas_q       <= meas_d;
      o_cmd_wr     <= (cmd_d.kind == KIND_WR);
      o_cmd_rd     <= (cmd_d.kind == KIND_RD);
      o_cmd_1byte  <= (cmd_d.kind == KIND_1B);
      o_tdc_cmd    <= cmd_d.op;
      o_tdc_wrdata <= cmd_d.wrdata;
      o_configured <= configured_d;
      o_busy       <= busy_d;
      o_res0       <= res0_d;
      o_res1       <= res1_d;
      o_res_valid  <= res_valid_d;
      o_err        <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    cnt_d        = cnt_q;
    meas_d       = meas_q;
    configured_d = o_configured;
    err_d        = o_err;
    res0_d       = o_res0;
    res1_d       = o_res1;
    res_valid_d  = 1'b0;

    unique case (state_q)
      S_IDLE, S_ERR: begin
        if (i_cfg_req) begin
          err_d        = 1'b0;
          configured_d = 1'b0;
          meas_d       = 1'b0;
          step_d       = STEP_RST;
          cnt_d        = '0;
          state_d      = S_REQ;
        end else if (i_meas_req && o_configured && (state_q == S_IDLE)) begin
          meas_d  = 1'b1;
          step_d  = STEP_INIT;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        if (i_cmd_ack) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CMD_TIMEOUT - 16'd1) begin
          err_d        = 1'b1;
          configured_d = 1'b0;
          state_d      = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_WAIT_DONE: begin
        if (i_cmd_done) begin
          if (step_q == STEP_RD0) res0_d = i_rd_data[31:8];
          if (step_q == STEP_RD1) begin
            res1_d      = i_rd_data[31:8];
            res_valid_d = 1'b1;
          end
          cnt_d   = '0;
          state_d = S_GAP;
        end else if (cnt_q == CMD_TIMEOUT - 16'd1) begin
          err_d        = 1'b1;
          configured_d = 1'b0;
          state_d      = S_ERR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Post-done quiet period before the next request or hand-off.
      S_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          case (step_q)
            STEP_INIT: begin
              if (meas_q) begin
                state_d = S_ARMED;
              end else begin
                configured_d = 1'b1;
                state_d      = S_IDLE;
              end
            end
            STEP_RD1: state_d = S_IDLE;
            default: begin
              step_d  = step_after(step_q);
              state_d = S_REQ;
            end
          endcase
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_ARMED: begin
        if (!i_tdc_intn) begin
          step_d  = STEP_RD0;
          cnt_d   = '0;
          state_d = S_REQ;
        end else if (cnt_q == INT_TIMEOUT - 16'd1) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    cmd_d  = (state_d == S_REQ) ? step_cmd(step_d) : '0;
    busy_d = !((state_d == S_IDLE) || (state_d == S_ERR));
  end

endmodule

// File: tb/tb_tdc_ms1004_seq.sv
// Scoreboard bench for tdc_ms1004_seq with a behavioural SPI-engine model.
module tb_tdc_ms1004_seq;

  localparam logic [15:0] INT_T = 16'd3000;
  localparam logic [15:0] CMD_T = 16'd1000;
  localparam int DONE_DLY = 168;

  typedef struct packed {
    logic [1:0]  kind;  // 1 wr, 2 rd, 3 opcode-only
    logic [7:0]  op;
    logic [31:0] wd;
  } exp_cmd_t;

  logic        clk;
  logic        i_rst_n, i_cfg_req, i_meas_req, i_tdc_intn;
  logic        o_cmd_wr, o_cmd_rd, o_cmd_1byte;
  logic [7:0]  o_tdc_cmd;
  logic [31:0] o_tdc_wrdata;
  logic        i_cmd_ack, i_cmd_done;
  logic [31:0] i_rd_data;
  logic        o_configured, o_busy, o_res_valid, o_err;
  logic [23:0] o_res0, o_res1;

  exp_cmd_t    exp_q[$];
  logic [31:0] rd_q[$];
  logic [47:0] res_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int res_valid_n = 0;
  int init_done_n = 0;
  int hang_cycles = 0;
  logic [7:0] hang_op = 8'h00;
  logic [7:0] wait_op = 8'h00;

  tdc_ms1004_seq #(
    .NUM_CFG(3), .CFG0(32'h0042_0000), .CFG1(32'h2144_0000), .CFG2(32'h0000_0000),
    .CFG3(32'h0000_0000), .CFG4(32'h0000_0000), .INT_TIMEOUT(INT_T), .CMD_TIMEOUT(CMD_T)
  ) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_cfg_req(i_cfg_req), .i_meas_req(i_meas_req),
    .i_tdc_intn(i_tdc_intn), .o_cmd_wr(o_cmd_wr), .o_cmd_rd(o_cmd_rd),
    .o_cmd_1byte(o_cmd_1byte), .o_tdc_cmd(o_tdc_cmd), .o_tdc_wrdata(o_tdc_wrdata),
    .i_cmd_ack(i_cmd_ack), .i_cmd_done(i_cmd_done), .i_rd_data(i_rd_data),
    .o_configured(o_configured), .o_busy(o_busy), .o_res0(o_res0), .o_res1(o_res1),
    .o_res_valid(o_res_valid), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_cmd(input logic [1:0] k, input logic [7:0] op, input logic [31:0] wd);
    exp_cmd_t e;
    e.kind = k; e.op = op; e.wd = wd;
    exp_q.push_back(e);
  endtask

  task automatic push_cfg_seq();
    push_cmd(2'd3, 8'h50, 32'h0);
    push_cmd(2'd1, 8'h80, 32'h0042_0000);
    push_cmd(2'd1, 8'h81, 32'h2144_0000);
    push_cmd(2'd1, 8'h82, 32'h0000_0000);
    push_cmd(2'd3, 8'h70, 32'h0);
  endtask

  task automatic pulse(input logic cfg, input logic meas);
    @(posedge clk); #1;
    i_cfg_req = cfg; i_meas_req = meas;
    @(posedge clk); #1;
    i_cfg_req = 1'b0; i_meas_req = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (o_busy && cyc < max_cyc);
    check("wait_idle_busy", 64'(o_busy), 64'd0);
  endtask

  task automatic wait_init_done();
    int base;
    int k;
    base = init_done_n;
    k = 0;
    while (init_done_n == base && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("init_done_seen", 64'(init_done_n != base), 64'd1);
  endtask

  // Engine model: pops the expected command on each new request, acks, then finishes.
  initial begin : engine
    exp_cmd_t e;
    logic [1:0] akind;
    logic [7:0] cur_op;
    logic       cur_rd;
    i_cmd_ack = 1'b0; i_cmd_done = 1'b0; i_rd_data = '0;
    forever begin
      @(negedge clk);
      if (i_rst_n && (o_cmd_wr || o_cmd_rd || o_cmd_1byte)) begin
        cur_op = o_tdc_cmd;
        cur_rd = o_cmd_rd;
        case ({o_cmd_wr, o_cmd_rd, o_cmd_1byte})
          3'b100:  akind = 2'd1;
          3'b010:  akind = 2'd2;
          3'b001:  akind = 2'd3;
          default: akind = 2'd0;
        endcase
        if (exp_q.size() == 0) begin
          check("unexpected_cmd", 64'(cur_op), 64'hFF);
        end else begin
          e = exp_q.pop_front();
          check("cmd_kind_op", 64'({akind, cur_op}), 64'({e.kind, e.op}));
          if (e.kind == 2'd1) check("cmd_wrdata", 64'(o_tdc_wrdata), 64'(e.wd));
        end
        if (cur_op == hang_op) begin
          hang_cycles = 0;
          while (i_rst_n && (o_cmd_wr || o_cmd_rd || o_cmd_1byte) && hang_cycles < 5000) begin
            hang_cycles++;
            @(negedge clk);
          end
        end else begin
          @(negedge clk);
          check("req_held_before_ack", 64'(o_cmd_wr | o_cmd_rd | o_cmd_1byte), 64'd1);
          i_cmd_ack = 1'b1;
          @(negedge clk);
          i_cmd_ack = 1'b0;
          check("req_dropped_after_ack", 64'(o_cmd_wr | o_cmd_rd | o_cmd_1byte), 64'd0);
          wait_op = cur_op;
          for (int k = 0; k < DONE_DLY && i_rst_n; k++) @(negedge clk);
          if (i_rst_n) begin
            if (cur_rd) i_rd_data = (rd_q.size() != 0) ? rd_q.pop_front() : 32'h0;
            i_cmd_done = 1'b1;
            @(negedge clk);
            i_cmd_done = 1'b0;
            if (cur_op == 8'h70) init_done_n++;
          end
          wait_op = 8'h00;
        end
      end
    end
  end

  // Result monitor: compares each valid strobe against the queued expectation.
  initial begin : res_mon
    logic [47:0] r;
    forever begin
      @(negedge clk);
      if (o_res_valid) begin
        res_valid_n++;
        if (res_q.size() == 0) begin
          check("unexpected_res_valid", 64'({o_res0, o_res1}), 64'h0);
        end else begin
          r = res_q.pop_front();
          check("res0", 64'(o_res0), 64'(r[47:24]));
          check("res1", 64'(o_res1), 64'(r[23:0]));
        end
      end
    end
  end

  initial begin : main
    int cyc;
    int vbase;
    int k;
    i_rst_n = 1'b0; i_cfg_req = 1'b0; i_meas_req = 1'b0; i_tdc_intn = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ctrl_outs", 64'({o_cmd_wr, o_cmd_rd, o_cmd_1byte, o_configured, o_busy, o_res_valid, o_err}), 64'd0);
    check("rst_cmd_data", 64'({o_tdc_cmd, o_tdc_wrdata}), 64'd0);
    check("rst_results", 64'({o_res0, o_res1}), 64'd0);
    @(posedge clk); #1 i_rst_n = 1'b1;

    // Measurement request before any configuration: nothing happens.
    pulse(1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("meas_unconfigured_busy", 64'(o_busy), 64'd0);

    // Full configuration; a measurement request mid-sequence is dropped.
    push_cfg_seq();
    pulse(1'b1, 1'b0);
    repeat (3) @(posedge clk);
    pulse(1'b0, 1'b1);
    wait_idle(3000, cyc);
    check("cfg_configured", 64'(o_configured), 64'd1);
    check("cfg_err", 64'(o_err), 64'd0);
    check("cfg_queue_drained", 64'(exp_q.size()), 64'd0);

    // Measurement with interrupt ~500 cycles after arming.
    push_cmd(2'd3, 8'h70, 32'h0);
    push_cmd(2'd2, 8'hB0, 32'h0);
    push_cmd(2'd2, 8'hB1, 32'h0);
    rd_q.push_back(32'hABCDEF00);
    rd_q.push_back(32'h12345600);
    res_q.push_back({24'hABCDEF, 24'h123456});
    vbase = res_valid_n;
    pulse(1'b0, 1'b1);
    wait_init_done();
    repeat (508) @(posedge clk);
    #1 i_tdc_intn = 1'b0;
    wait_idle(3000, cyc);
    i_tdc_intn = 1'b1;
    check("res_valid_pulses", 64'(res_valid_n - vbase), 64'd1);
    check("res0_held", 64'(o_res0), 64'hABCDEF);
    check("res1_held", 64'(o_res1), 64'h123456);
    check("meas_configured", 64'(o_configured), 64'd1);
    check("meas_queue_drained", 64'(exp_q.size()), 64'd0);

    // Interrupt never arrives.
    push_cmd(2'd3, 8'h70, 32'h0);
    pulse(1'b0, 1'b1);
    wait_init_done();
    wait_idle(int'(INT_T) + 500, cyc);
    check("int_to_err", 64'(o_err), 64'd1);
    check("int_to_configured_kept", 64'(o_configured), 64'd1);
    check("int_to_length_ok", 64'(cyc >= int'(INT_T) && cyc <= int'(INT_T) + 20), 64'd1);
    check("int_to_no_read", 64'(exp_q.size()), 64'd0);

    // Command timeout on CFG1 write.
    push_cmd(2'd3, 8'h50, 32'h0);
    push_cmd(2'd1, 8'h80, 32'h0042_0000);
    push_cmd(2'd1, 8'h81, 32'h2144_0000);
    hang_op = 8'h81;
    pulse(1'b1, 1'b0);
    @(negedge clk);
    check("err_cleared_by_cfg", 64'(o_err), 64'd0);
    wait_idle(3000, cyc);
    check("cmd_to_err", 64'(o_err), 64'd1);
    check("cmd_to_configured", 64'(o_configured), 64'd0);
    check("cmd_to_req_len_ok", 64'(hang_cycles >= int'(CMD_T) - 2 && hang_cycles <= int'(CMD_T) + 2), 64'd1);
    check("cmd_to_queue_drained", 64'(exp_q.size()), 64'd0);
    hang_op = 8'h00;
    pulse(1'b0, 1'b1);
    repeat (20) @(negedge clk);
    check("meas_in_err_ignored", 64'(o_busy), 64'd0);

    // Recovery from ERR with simultaneous requests: configuration wins.
    push_cfg_seq();
    pulse(1'b1, 1'b1);
    @(negedge clk);
    check("restart_err_cleared", 64'(o_err), 64'd0);
    wait_idle(3000, cyc);
    check("restart_configured", 64'(o_configured), 64'd1);
    check("restart_queue_drained", 64'(exp_q.size()), 64'd0);

    // Reset while waiting for CFG1 done.
    push_cfg_seq();
    pulse(1'b1, 1'b0);
    k = 0;
    while (wait_op != 8'h81 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("cfg1_wait_seen", 64'(wait_op), 64'h81);
    @(posedge clk); #1 i_rst_n = 1'b0;
    @(negedge clk);
    check("midrst_ctrl_outs", 64'({o_cmd_wr, o_cmd_rd, o_cmd_1byte, o_configured, o_busy, o_res_valid, o_err}), 64'd0);
    check("midrst_results", 64'({o_res0, o_res1}), 64'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 i_rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("post_rst_idle", 64'({o_busy, o_configured}), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
